// File: rtl/pipeline_feeder.sv
// Buffered source stage feeding a free-running pipeline: valid/ready input into a
// circular FIFO, with a registered output that carries zero bubbles whenever nothing drains.
module pipeline_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       hold_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign ready_o = (count != CW'(DEPTH));
  assign level_o = count;
  assign do_wr   = valid_i && ready_o;
  assign do_rd   = (count != '0) && !hold_i;

  // Storage is deliberately left out of reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // A bubble always drives zero so the pipeline never sees stale words.
      if (do_rd) begin
        data_o  <= mem[rd_ptr];
        valid_o <= 1'b1;
        rd_ptr  <= rd_ptr + AW'(1);
      end else begin
        data_o  <= '0;
        valid_o <= 1'b0;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_feeder.sv
// Directed and randomized bench for pipeline_feeder, checked against a queue-based
// model of the FIFO and an independent record of the words seen on the output.
module tb_pipeline_feeder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             hold_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic [$clog2(DEPTH):0] level_o;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] outQ[$];
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] expData;
  logic             expValid;

  pipeline_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .hold_i (hold_i),
    .data_o (data_o),
    .valid_o(valid_o),
    .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every output sample against the model and logs real words seen.
  task automatic checkOutput();
    check("data_o", 32'(data_o), 32'(expData));
    check("valid_o", 32'(valid_o), 32'(expValid));
    check("level_o", 32'(level_o), 32'(modelQ.size()));
    check("level_bound", 32'(level_o <= DEPTH), 32'd1);
    if (valid_o === 1'b1) outQ.push_back(data_o);
  endtask

  // Called just after a rising edge: drives inputs, then advances one edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic h,
                               output logic acc);
    logic expReady;
    valid_i  = v;
    data_i   = d;
    hold_i   = h;
    expReady = (modelQ.size() != DEPTH);
    #1;
    check("ready_o", 32'(ready_o), 32'(expReady));
    acc = v && expReady;
    @(posedge clk);
    if (modelQ.size() != 0 && !h) begin
      expData  = modelQ.pop_front();
      expValid = 1'b1;
    end else begin
      expData  = '0;
      expValid = 1'b0;
    end
    if (acc) modelQ.push_back(d);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    #2;
    rst = 1'b1;
    modelQ.delete();
    outQ.delete();
    expData  = '0;
    expValid = 1'b0;
    #1;
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_level_o", 32'(level_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkSeq(input string tag);
    check({tag, "_len"}, 32'(outQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < outQ.size(); i++) begin
      check(tag, 32'(outQ[i]), 32'(expQ[i]));
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 2 * DEPTH && (modelQ.size() != 0 || valid_o === 1'b1); i++) begin
      applyStimulus(1'b0, '0, 1'b0, acc);
    end
  endtask

  initial begin
    logic acc;
    int   guard;
    rst      = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
    hold_i   = 1'b0;
    expData  = '0;
    expValid = 1'b0;

    $display("[TB] reset state");
    doReset();

    $display("[TB] single word");
    outQ.delete();
    applyStimulus(1'b1, 8'hA5, 1'b0, acc);
    check("single_acc", 32'(acc), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, acc);
    check("single_valid", 32'(valid_o), 32'd1);
    check("single_data", 32'(data_o), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, acc);
    check("single_bubble", 32'(data_o), 32'd0);

    $display("[TB] fill with hold");
    outQ.delete();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b1, acc);
    check("fill_level", 32'(level_o), 32'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h05, 1'b1, acc);
      check("full_reject", 32'(acc), 32'd0);
    end
    acc = 1'b0;
    for (guard = 0; guard < 8 && !acc; guard++) applyStimulus(1'b1, 8'h05, 1'b0, acc);
    check("fill_5_accepted", 32'(acc), 32'd1);
    drain();
    expQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    checkSeq("fill_order");

    $display("[TB] full plus drain on the same edge");
    outQ.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, acc);
    applyStimulus(1'b1, 8'h14, 1'b0, acc);
    check("same_edge_rej", 32'(acc), 32'd0);
    check("same_edge_l3", 32'(level_o), 32'd3);
    applyStimulus(1'b1, 8'h14, 1'b1, acc);
    check("same_edge_acc", 32'(acc), 32'd1);
    check("same_edge_l4", 32'(level_o), 32'd4);
    drain();
    expQ = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    checkSeq("same_edge_order");

    $display("[TB] wrap-around stream");
    outQ.delete();
    expQ.delete();
    for (int w = 0; w < 20; w++) begin
      expQ.push_back(8'(w));
      acc = 1'b0;
      for (guard = 0; guard < 50 && !acc; guard++) begin
        applyStimulus(1'b1, 8'(w), ($urandom_range(0, 99) < 30), acc);
      end
      if (!acc) check("stream_timeout", 32'd0, 32'd1);
    end
    drain();
    checkSeq("stream_order");

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b1, acc);
    check("pre_reset_level", 32'(level_o), 32'd3);
    doReset();
    applyStimulus(1'b1, 8'h7E, 1'b0, acc);
    check("post_reset_acc", 32'(acc), 32'd1);
    check("post_reset_bubble", 32'(valid_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, acc);
    check("post_reset_data", 32'(data_o), 32'h7E);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, acc);
    expQ = '{8'h7E};
    checkSeq("post_reset_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
